mul3_iter_ctrl: RTL



---
 rtl/mul3_iter_ctrl_if.sv | 25 ++
 rtl/mul3_iter_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mul3_iter_ctrl_if.sv
// ap_ctrl_hs request/response bundle for the three-operand multiply kernel.
// The controller drives start and operands; the kernel returns status and result.
interface mul3_iter_ctrl_if #(
  parameter int W = 32
);
  logic         ap_start;
  logic         ap_done;
  logic         ap_idle;
  logic         ap_ready;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic [W-1:0] ap_return;

  modport master (
    output ap_start, mode, a, b, c,
    input  ap_done, ap_idle, ap_ready, ap_return
  );

  modport slave (
    input  ap_start, mode, a, b, c,
    output ap_done, ap_idle, ap_ready, ap_return
  );
endinterface

// File: rtl/mul3_iter_ctrl.sv
// Iterative shift-add kernel: (a*c)*b or (a*c)+b, W-bit wrap.
// One multiplier bit per cycle; optional early exit on zero multiplier.
module mul3_iter_ctrl #(
  parameter int W          = 32,
  parameter int EARLY_TERM = 1
) (
  input  logic           ap_clk,
  input  logic           ap_rst_n,
  mul3_iter_ctrl_if.slave bus
);
  localparam int CW = $clog2(W);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL1 = 3'd1,
    S_MUL2 = 3'd2,
    S_ADD  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]  mplr_q, mplr_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  ret_q, ret_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W-1:0]  step_acc;
  logic [W-1:0]  mplr_sh;
  logic          last;
  logic          accept;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      ret_q   <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      ret_q   <= ret_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    b_d      = b_q;
    ret_d    = ret_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    step_acc = acc_q + (mplr_q[0] ? mcand_q : '0);
    mplr_sh  = mplr_q >> 1;
    if (EARLY_TERM != 0) begin
      last = (mplr_sh == '0);
    end else begin
      last = (cnt_q == CW'(W - 1));
    end
    // Ready is masked in reset so no acceptance is ever advertised there.
    accept = ap_rst_n && bus.ap_start &&
             ((state_q == S_IDLE) || (state_q == S_DONE));

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = S_MUL1;
          mcand_d = bus.a;
          mplr_d  = bus.c;
          acc_d   = '0;
          b_d     = bus.b;
          mode_d  = bus.mode;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL1: begin
        acc_d   = step_acc;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_sh;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          cnt_d = '0;
          if (!mode_q) begin
            state_d = S_MUL2;
            mcand_d = step_acc;
            mplr_d  = b_q;
            acc_d   = '0;
          end else begin
            state_d = S_ADD;
          end
        end
      end
      S_MUL2: begin
        acc_d   = step_acc;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_sh;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          cnt_d   = '0;
          state_d = S_DONE;
          ret_d   = step_acc;
        end
      end
      S_ADD: begin
        state_d = S_DONE;
        ret_d   = acc_q + b_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.ap_ready  = accept;
  assign bus.ap_done   = (state_q == S_DONE);
  assign bus.ap_idle   = (state_q == S_IDLE) && !bus.ap_start;
  assign bus.ap_return = ret_q;
endmodule
